// File: rtl/note_scheduler.sv
// Chart sequencer: fetches rows from a synchronous chart ROM and emits each lane mask for one frame.
// Optional NOTE_SCHED_LOOP_EN: the end marker rewinds to row 0 instead of finishing.
module note_scheduler #(
  parameter int ADDR_W      = 8,
  parameter int STEP_FRAMES = 4
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              frame_clk,
  input  logic              start,
  input  logic              pause,
  input  logic [8:0]        rom_data,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [3:0]        display_signal,
  output logic              busy,
  output logic              done,
  output logic [9:0]        row_count
);

  // state | meaning
  // IDLE  | waiting for start after reset
  // FETCH | rom_addr presented, ROM data returns next cycle
  // LOAD  | capture next row (mask, duration, end marker)
  // ARM   | first row loaded, wait for a frame edge to emit it
  // RUN   | counting down the current row's duration
  // DONE  | chart finished, waiting for start
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_ARM, S_RUN, S_DONE
  } state_t;

  localparam logic [7:0]        STEP     = 8'(STEP_FRAMES);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t            state, state_nxt;
  logic              frame_dly;
  logic              frame_edge;
  logic              advance;
  logic              emit;
  logic              wrap;
  logic              first_row;
  logic              next_end;
  logic [3:0]        next_mask;
  logic [7:0]        next_dur;
  logic [7:0]        cnt;
  logic [7:0]        dur_calc;
  logic [ADDR_W-1:0] addr;

  always_comb begin
    frame_edge = frame_clk & ~frame_dly;
    advance    = frame_edge & ~pause;
    dur_calc   = ({4'b0000, rom_data[7:4]} + 8'd1) * STEP;
    state_nxt  = state;
    emit       = 1'b0;
    wrap       = 1'b0;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_FETCH;
      S_FETCH:        state_nxt = S_LOAD;
      S_LOAD: begin
        if (rom_data[8] && addr == '0) state_nxt = S_DONE;
`ifdef NOTE_SCHED_LOOP_EN
        else if (rom_data[8]) begin
          wrap      = 1'b1;
          state_nxt = S_FETCH;
        end
`endif
        else if (first_row) state_nxt = S_ARM;
        else                state_nxt = S_RUN;
      end
      S_ARM: begin
        if (advance) begin
          emit      = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_RUN: begin
        if (advance && cnt <= 8'd1) begin
          if (next_end) state_nxt = S_DONE;
          else begin
            emit      = 1'b1;
            state_nxt = S_FETCH;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state          <= S_IDLE;
      frame_dly      <= 1'b0;
      addr           <= '0;
      row_count      <= '0;
      cnt            <= '0;
      display_signal <= '0;
      next_mask      <= '0;
      next_dur       <= '0;
      next_end       <= 1'b0;
      first_row      <= 1'b0;
    end else begin
      state     <= state_nxt;
      frame_dly <= frame_clk;
      if ((state == S_IDLE || state == S_DONE) && start) begin
        addr      <= '0;
        row_count <= '0;
        first_row <= 1'b1;
      end
      if (state == S_LOAD) begin
        next_mask <= rom_data[3:0];
        next_dur  <= dur_calc;
        next_end  <= rom_data[8];
      end
      if (wrap) addr <= '0;
      // Paused edges only clear the mask; the frozen frame is not counted.
      if (frame_edge && (state == S_ARM || state == S_RUN)) begin
        if (emit) begin
          display_signal <= next_mask;
          cnt            <= next_dur;
          addr           <= addr + ADDR_ONE;
          row_count      <= row_count + 10'd1;
          first_row      <= 1'b0;
        end else begin
          display_signal <= '0;
          if (advance) cnt <= cnt - 8'd1;
        end
      end
    end
  end

  assign rom_addr = addr;
  assign busy     = (state == S_FETCH) || (state == S_LOAD) ||
                    (state == S_ARM)   || (state == S_RUN);
  assign done     = (state == S_DONE);

endmodule

// File: tb/tb_note_scheduler.sv
// Bench for note_scheduler: per-edge vector tables, emission scoreboard and hand-written corner sequences.
// Expectations follow NOTE_SCHED_LOOP_EN when it is defined.
module tb_note_scheduler;
  localparam int ADDR_W      = 8;
  localparam int STEP_FRAMES = 4;
  localparam int FRAME_CYC   = 16;

  logic              Clk = 1'b0;
  logic              reset = 1'b1;
  logic              frame_clk = 1'b0;
  logic              start = 1'b0;
  logic              pause = 1'b0;
  logic [8:0]        rom_data;
  logic [ADDR_W-1:0] rom_addr;
  logic [3:0]        display_signal;
  logic              busy;
  logic              done;
  logic [9:0]        row_count;

  note_scheduler #(.ADDR_W(ADDR_W), .STEP_FRAMES(STEP_FRAMES)) dut (
    .Clk(Clk), .reset(reset), .frame_clk(frame_clk), .start(start), .pause(pause),
    .rom_data(rom_data), .rom_addr(rom_addr), .display_signal(display_signal),
    .busy(busy), .done(done), .row_count(row_count)
  );

  always #5 Clk = ~Clk;

  logic [8:0] chart [0:255];
  always_ff @(posedge Clk) rom_data <= chart[rom_addr];

  typedef struct {
    logic [3:0] mask;
    int         edge_no;
  } emit_t;

  typedef struct {
    logic       p;
    logic [3:0] disp;
    logic       dn;
    logic       bz;
    logic [9:0] rc;
  } vec_t;

  int    tests    = 0;
  int    failed   = 0;
  int    edge_cnt = 0;
  emit_t exp_q[$];
  vec_t  vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic add(input logic p, input logic [3:0] d, input logic dn, input logic bz,
                     input logic [9:0] rc, input int reps);
    vec_t v;
    v.p = p; v.disp = d; v.dn = dn; v.bz = bz; v.rc = rc;
    for (int i = 0; i < reps; i++) vecs.push_back(v);
  endtask

  // One frame: rising frame_clk (with pause level), sample the cycle after the edge.
  task automatic run_vecs(input string tag);
    vec_t v;
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      pause     = v.p;
      frame_clk = 1'b1;
      edge_cnt++;
      if (v.disp != 4'd0) exp_q.push_back('{v.disp, edge_cnt});
      @(negedge Clk);
      chk($sformatf("%s[%0d].disp", tag, i), 32'(display_signal), 32'(v.disp));
      chk($sformatf("%s[%0d].done", tag, i), 32'(done), 32'(v.dn));
      chk($sformatf("%s[%0d].busy", tag, i), 32'(busy), 32'(v.bz));
      chk($sformatf("%s[%0d].rc", tag, i), 32'(row_count), 32'(v.rc));
      tick(1);
      frame_clk = 1'b0;
      pause     = 1'b0;
      tick(FRAME_CYC - 2);
    end
    vecs.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Scoreboard: every new nonzero mask must match the next expected emission and its edge.
  logic [3:0] prev_disp = 4'd0;
  always @(negedge Clk) begin
    emit_t e;
    if (display_signal != 4'd0 && prev_disp == 4'd0) begin
      if (exp_q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL sb_unexpected: got mask %0d at edge %0d, expected none", display_signal, edge_cnt);
      end else begin
        e = exp_q.pop_front();
        chk("sb_mask", 32'(display_signal), 32'(e.mask));
        chk("sb_edge", 32'(edge_cnt), 32'(e.edge_no));
      end
    end
    prev_disp = display_signal;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) chart[i] = 9'h000;
    chart[0] = 9'h001;
    chart[1] = 9'h016;
    chart[2] = 9'h100;

    tick(3);
    chk("rst.disp", 32'(display_signal), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.rc", 32'(row_count), 0);
    chk("rst.addr", 32'(rom_addr), 0);
    reset = 1'b0;
    tick(2);

    pulse_start();
    chk("start.fetch_busy", 32'(busy), 1);
    chk("start.fetch_addr", 32'(rom_addr), 0);
    tick(1);
    chk("start.load_busy", 32'(busy), 1);
    tick(1);
    chk("start.arm_disp", 32'(display_signal), 0);

`ifdef NOTE_SCHED_LOOP_EN
    add(0, 4'd1, 0, 1, 10'd1, 1);
    add(0, 4'd0, 0, 1, 10'd1, 3);
    add(0, 4'd6, 0, 1, 10'd2, 1);
    add(0, 4'd0, 0, 1, 10'd2, 7);
    add(0, 4'd1, 0, 1, 10'd3, 1);
    add(0, 4'd0, 0, 1, 10'd3, 3);
    add(0, 4'd6, 0, 1, 10'd4, 1);
    run_vecs("loop");
`else
    add(0, 4'd1, 0, 1, 10'd1, 1);
    add(0, 4'd0, 0, 1, 10'd1, 3);
    add(0, 4'd6, 0, 1, 10'd2, 1);
    add(0, 4'd0, 0, 1, 10'd2, 7);
    add(0, 4'd0, 1, 0, 10'd2, 1);
    run_vecs("nominal");

    pulse_start();
    chk("restart.rc", 32'(row_count), 0);
    chk("restart.done", 32'(done), 0);
    chk("restart.busy", 32'(busy), 1);
    tick(2);
    add(0, 4'd1, 0, 1, 10'd1, 1);
    add(1, 4'd0, 0, 1, 10'd1, 3);
    add(0, 4'd0, 0, 1, 10'd1, 3);
    add(0, 4'd6, 0, 1, 10'd2, 1);
    add(0, 4'd0, 0, 1, 10'd2, 7);
    add(0, 4'd0, 1, 0, 10'd2, 1);
    run_vecs("pause");
`endif

    // Empty chart: done three cycles after start, nothing emitted.
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    chart[0] = 9'h100;
    pulse_start();
    chk("empty.t1_busy", 32'(busy), 1);
    tick(1);
    chk("empty.t2_busy", 32'(busy), 1);
    chk("empty.t2_done", 32'(done), 0);
    tick(1);
    chk("empty.t3_done", 32'(done), 1);
    chk("empty.t3_busy", 32'(busy), 0);
    add(0, 4'd0, 1, 0, 10'd0, 3);
    run_vecs("empty");

    // Reset while a mask is displayed in RUN.
    chart[0] = 9'h001;
    pulse_start();
    tick(2);
    add(0, 4'd1, 0, 1, 10'd1, 1);
    add(0, 4'd0, 0, 1, 10'd1, 3);
    add(0, 4'd6, 0, 1, 10'd2, 1);
    run_vecs("prerst");
    chk("midrst.before_disp", 32'(display_signal), 6);
    reset = 1'b1;
    tick(1);
    chk("midrst.disp", 32'(display_signal), 0);
    chk("midrst.busy", 32'(busy), 0);
    chk("midrst.done", 32'(done), 0);
    chk("midrst.rc", 32'(row_count), 0);
    chk("midrst.addr", 32'(rom_addr), 0);
    reset = 1'b0;
    tick(2);

    // Replay from row 0, with a start pulse ignored during RUN.
    pulse_start();
    tick(2);
    add(0, 4'd1, 0, 1, 10'd1, 1);
    run_vecs("replay");
    pulse_start();
    tick(2);
    chk("runstart.rc", 32'(row_count), 1);
    chk("runstart.addr", 32'(rom_addr), 1);
    chk("runstart.busy", 32'(busy), 1);
    add(0, 4'd0, 0, 1, 10'd1, 3);
    add(0, 4'd6, 0, 1, 10'd2, 1);
    add(0, 4'd0, 0, 1, 10'd2, 7);
`ifdef NOTE_SCHED_LOOP_EN
    add(0, 4'd1, 0, 1, 10'd3, 1);
`else
    add(0, 4'd0, 1, 0, 10'd2, 1);
`endif
    run_vecs("replay2");

    tick(2);
    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
